// File: rtl/stack_rpn_ctrl_if.sv
// rtl/stack_rpn_ctrl_if.sv - command/result bus between a command source and stack_rpn_ctrl
// Ports (signals):
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command handshake, master -> controller
//   res_valid/res_data                  : completion pulse and result, controller -> master
//   err                                 : rejection pulse, controller -> master
interface stack_rpn_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  err;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, res_valid, res_data, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, res_valid, res_data, err
  );
endinterface

// File: rtl/stack_rpn_ctrl.sv
// rtl/stack_rpn_ctrl.sv - RPN command sequencer, sole master of the LIFO stack
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-low reset
//   cmd (slave modport) : command handshake in, result/err pulses out
//   depth               : current stack occupancy tracked locally
//   stk_push/stk_pop    : stack strobes, never both high
//   stk_wdata           : push data, zero when not pushing
//   stk_rdata           : stack read data, valid the cycle after stk_pop
module stack_rpn_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  stack_rpn_ctrl_if.slave                    cmd,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stk_push,
  output logic                               stk_pop,
  output logic [DATA_WIDTH-1:0]              stk_wdata,
  input  logic [DATA_WIDTH-1:0]              stk_rdata
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH+1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_ERR, S_PUSH_I, S_POP_B, S_WAIT_B,
    S_POP_A, S_WAIT_A, S_PUSH_R, S_PUSH_D, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_PUSH = 3'b000, OP_POP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DUP
  } op_t;

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  legal;
  logic [DATA_WIDTH-1:0] alu;
  op_t                   new_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_PUSH;
      imm_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      depth_q <= depth_d;
    end
  end

  // Legality of the offered command, judged only from the local occupancy count.
  always_comb begin
    new_op = op_t'(cmd.cmd_op);
    legal  = 1'b0;
    case (new_op)
      OP_PUSH: legal = (depth_q < DEPTH_MAX);
      OP_POP:  legal = (depth_q >= DEPTH_W'(1));
      OP_DUP:  legal = (depth_q >= DEPTH_W'(1)) && (depth_q < DEPTH_MAX);
      default: legal = (depth_q >= DEPTH_W'(2));
    endcase
  end

  // B is the former top entry, A the one beneath it; DUP reuses B unchanged.
  always_comb begin
    alu = opb_q;
    case (op_q)
      OP_ADD:  alu = opa_q + opb_q;
      OP_SUB:  alu = opa_q - opb_q;
      OP_AND:  alu = opa_q & opb_q;
      OP_OR:   alu = opa_q | opb_q;
      OP_XOR:  alu = opa_q ^ opb_q;
      default: alu = opb_q;
    endcase
  end

  // Moore outputs
  always_comb begin
    cmd.cmd_ready = (state_q == S_IDLE);
    cmd.res_valid = (state_q == S_DONE);
    cmd.err       = (state_q == S_ERR);
    cmd.res_data  = res_q;
    depth         = depth_q;
    stk_push      = (state_q == S_PUSH_I) || (state_q == S_PUSH_R) || (state_q == S_PUSH_D);
    stk_pop       = (state_q == S_POP_B) || (state_q == S_POP_A);
    stk_wdata     = '0;
    case (state_q)
      S_PUSH_I: stk_wdata = imm_q;
      S_PUSH_R: stk_wdata = alu;
      S_PUSH_D: stk_wdata = opb_q;
      default:  stk_wdata = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    depth_d = depth_q;

    if (stk_push)     depth_d = depth_q + DEPTH_W'(1);
    else if (stk_pop) depth_d = depth_q - DEPTH_W'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d  = new_op;
          imm_d = cmd.cmd_data;
          if (!legal)                state_d = S_ERR;
          else if (new_op == OP_PUSH) state_d = S_PUSH_I;
          else                       state_d = S_POP_B;
        end
      end
      S_ERR:    state_d = S_IDLE;
      S_PUSH_I: begin
        res_d   = imm_q;
        state_d = S_DONE;
      end
      S_POP_B:  state_d = S_WAIT_B;
      S_WAIT_B: begin
        // Stack read data becomes valid here, one cycle after the pop strobe.
        opb_d = stk_rdata;
        if (op_q == OP_POP) begin
          res_d   = stk_rdata;
          state_d = S_DONE;
        end else if (op_q == OP_DUP) begin
          state_d = S_PUSH_R;
        end else begin
          state_d = S_POP_A;
        end
      end
      S_POP_A:  state_d = S_WAIT_A;
      S_WAIT_A: begin
        opa_d   = stk_rdata;
        state_d = S_PUSH_R;
      end
      S_PUSH_R: begin
        if (op_q == OP_DUP) begin
          state_d = S_PUSH_D;
        end else begin
          res_d   = alu;
          state_d = S_DONE;
        end
      end
      S_PUSH_D: begin
        res_d   = opb_q;
        state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_rpn_ctrl.sv
// tb/tb_stack_rpn_ctrl.sv - self-checking bench for stack_rpn_ctrl with a LIFO model behind it
module tb_stack_rpn_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    depth;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_wdata;
  logic [DW-1:0] stk_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  stack_rpn_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  stack_rpn_ctrl #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (bus),
    .depth     (depth),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_rdata (stk_rdata)
  );

  always #5 clk = ~clk;

  // The physical stack: registered read data one cycle after pop, shares reset.
  logic [DW-1:0] mem [0:7];
  int            sp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp        <= 0;
      stk_rdata <= '0;
    end else if (stk_push && sp < 8) begin
      mem[sp] <= stk_wdata;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_rdata <= mem[sp-1];
      sp        <= sp - 1;
    end
  end

  // Reference model: queue with the top entry at the back.
  logic [DW-1:0] mdl [$];
  logic [DW-1:0] last_res = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reset_vec();
    return {9'd0, bus.cmd_ready, bus.res_valid, bus.err, stk_push, stk_pop,
            stk_wdata, bus.res_data, depth};
  endfunction

  localparam logic [31:0] RESET_EXP = {9'd0, 1'b1, 4'b0000, 8'h00, 8'h00, 2'b00};

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [DW-1:0] data);
    int            d0, exp_lat, done_n, pushes, viol, w;
    logic          legal, exp_err, obs_err;
    logic [DW-1:0] a, b, r, obs_res;
    logic [15:0]   exp_pop_m, exp_push_m, obs_pop_m, obs_push_m, exp_pd, obs_pd;
    logic [1:0]    obs_depth;

    d0 = mdl.size();
    case (op)
      3'd0:    legal = d0 < DEPTH;
      3'd1:    legal = d0 >= 1;
      3'd7:    legal = d0 >= 1 && d0 < DEPTH;
      default: legal = d0 >= 2;
    endcase
    exp_err = !legal;
    exp_pop_m = 0; exp_push_m = 0; exp_pd = 0; r = last_res; exp_lat = 1;
    if (legal) begin
      case (op)
        3'd0: begin
          r = data; mdl.push_back(data);
          exp_lat = 2; exp_push_m = 16'h0002; exp_pd = {data, 8'h00};
        end
        3'd1: begin
          r = mdl.pop_back();
          exp_lat = 3; exp_pop_m = 16'h0002;
        end
        3'd7: begin
          b = mdl[$]; r = b; mdl.push_back(b);
          exp_lat = 5; exp_pop_m = 16'h0002; exp_push_m = 16'h0018; exp_pd = {b, b};
        end
        default: begin
          b = mdl.pop_back();
          a = mdl.pop_back();
          case (op)
            3'd2:    r = a + b;
            3'd3:    r = a - b;
            3'd4:    r = a & b;
            3'd5:    r = a | b;
            default: r = a ^ b;
          endcase
          mdl.push_back(r);
          exp_lat = 6; exp_pop_m = 16'h000A; exp_push_m = 16'h0020; exp_pd = {r, 8'h00};
        end
      endcase
      last_res = r;
    end

    w = 0;
    while (!bus.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clk);

    done_n = 0; pushes = 0; viol = 0;
    obs_pop_m = 0; obs_push_m = 0; obs_pd = 0; obs_err = 0; obs_res = 0; obs_depth = 0;
    // Command is held valid while busy; it must not be accepted again.
    for (int c = 1; c <= 12 && done_n == 0; c++) begin
      @(negedge clk);
      if (stk_push) begin
        obs_push_m[c] = 1'b1;
        if (pushes == 0)      obs_pd[15:8] = stk_wdata;
        else if (pushes == 1) obs_pd[7:0]  = stk_wdata;
        pushes++;
      end else if (stk_wdata != 0) begin
        viol++;
      end
      if (stk_pop) obs_pop_m[c] = 1'b1;
      if (stk_push && stk_pop) viol++;
      if (bus.res_valid && bus.err) viol++;
      if (bus.cmd_ready) viol++;
      if (bus.res_valid || bus.err) begin
        done_n    = c;
        obs_err   = bus.err;
        obs_res   = bus.res_data;
        obs_depth = depth;
      end
    end
    bus.cmd_valid = 1'b0;

    check({tag, ".latency"}, done_n, exp_lat);
    check({tag, ".err"}, obs_err, exp_err);
    check({tag, ".res_data"}, obs_res, r);
    check({tag, ".depth"}, obs_depth, mdl.size());
    check({tag, ".pop_cycles"}, obs_pop_m, exp_pop_m);
    check({tag, ".push_cycles"}, obs_push_m, exp_push_m);
    check({tag, ".push_data"}, obs_pd, exp_pd);
    check({tag, ".protocol"}, viol, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = '0;

    repeat (3) @(negedge clk);
    check("reset_hold", reset_vec(), RESET_EXP);
    rst = 1'b1;
    @(negedge clk);
    check("after_reset", reset_vec(), RESET_EXP);

    run_cmd("push05", 3'd0, 8'h05);
    run_cmd("push03", 3'd0, 8'h03);
    run_cmd("sub_02", 3'd3, 8'h00);
    run_cmd("push03b", 3'd0, 8'h03);
    run_cmd("sub_wrap", 3'd3, 8'h00);
    run_cmd("pop_ff", 3'd1, 8'h00);
    run_cmd("pop_empty", 3'd1, 8'h00);
    run_cmd("pushf0", 3'd0, 8'hF0);
    run_cmd("add_depth1", 3'd2, 8'h00);
    run_cmd("push20", 3'd0, 8'h20);
    run_cmd("add_carry", 3'd2, 8'h00);
    run_cmd("push07", 3'd0, 8'h07);
    run_cmd("dup07", 3'd7, 8'h00);
    run_cmd("push_full", 3'd0, 8'h99);
    run_cmd("dup_full", 3'd7, 8'h00);

    // Reset asserted during cycle 3 of an ADD (second pop).
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd2;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("add_cycle3_pop", stk_pop, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_cmd_reset", reset_vec(), RESET_EXP);
    bus.cmd_valid = 1'b0;
    mdl.delete();
    last_res = '0;
    @(negedge clk);
    rst = 1'b1;
    run_cmd("push01", 3'd0, 8'h01);
    run_cmd("pop01", 3'd1, 8'h00);

    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      run_cmd($sformatf("rand%0d", i), rop, 8'($urandom));
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
